// File: rtl/cpu_clock_controller_if.sv
// Front-panel / CPU-core bundle for the clock controller.
// The master side (panel and core) drives rate_sel, run_req, step_req and halt_in.
// The slave side (cpu_clock_controller) drives cpu_ce, phase, state, halted and cycle_count.
interface cpu_clock_controller_if #(
   parameter int unsigned SEL_W = 3,
   parameter int unsigned CNT_W = 16
);
   logic [SEL_W-1:0] rate_sel;
   logic             run_req;
   logic             step_req;
   logic             halt_in;
   logic             cpu_ce;
   logic             phase;
   logic [1:0]       state;
   logic             halted;
   logic [CNT_W-1:0] cycle_count;

   modport master (
      output rate_sel, run_req, step_req, halt_in,
      input  cpu_ce, phase, state, halted, cycle_count
   );

   modport slave (
      input  rate_sel, run_req, step_req, halt_in,
      output cpu_ce, phase, state, halted, cycle_count
   );
endinterface

// File: rtl/cpu_clock_controller.sv
// Run/halt/single-step scheduler for the 8-bit CPU. It issues a one-cycle enable, cpu_ce,
// every 2^sel_act clk cycles while running or stepping, so the core stays synchronous to clk.
// Ports:
//   clk   - system clock, rising edge
//   reset - asynchronous, active-low
//   bus   - slave modport: rate_sel/run_req/step_req/halt_in in;
//           cpu_ce/phase/state/halted/cycle_count out
module cpu_clock_controller #(
   parameter int unsigned SEL_W = 3,
   parameter int unsigned CNT_W = 16
) (
   input logic                  clk,
   input logic                  reset,
   cpu_clock_controller_if.slave bus
);

   // The prescaler must reach 2^(2^SEL_W-1)-1, which needs 2^SEL_W-1 bits.
   localparam int unsigned CntW = (1 << SEL_W) - 1;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StRun    = 2'd1,
      StStep   = 2'd2,
      StHalted = 2'd3
   } state_e;

   state_e           state_q, state_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [SEL_W-1:0] sel_act_q, sel_act_d;
   logic             step_q, step_d;
   logic             phase_q, phase_d;
   logic [CNT_W-1:0] cycle_count_q, cycle_count_d;

   logic [CntW-1:0] term;
   logic            active;
   logic            tick;
   logic            step_edge;

   // term = 2^sel_act - 1 as a run of low-order ones
   assign term      = ~({CntW{1'b1}} << sel_act_q);
   assign active    = (state_q == StRun) || (state_q == StStep);
   assign tick      = active && (cnt_q == term);
   assign step_edge = bus.step_req && !step_q;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (bus.halt_in)      state_d = StHalted;
            else if (bus.run_req) state_d = StRun;
            else if (step_edge)   state_d = StStep;
         end
         StRun: begin
            if (bus.halt_in)       state_d = StHalted;
            else if (!bus.run_req) state_d = StIdle;
         end
         StStep: begin
            if (bus.halt_in) state_d = StHalted;
            else if (tick)   state_d = StIdle;
         end
         StHalted: begin
            if (!bus.halt_in && !bus.run_req) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      cnt_d         = '0;
      sel_act_d     = sel_act_q;
      step_d        = bus.step_req;
      phase_d       = phase_q ^ tick;
      cycle_count_d = cycle_count_q + (tick ? CNT_W'(1) : CNT_W'(0));

      // Any state change restarts the period; otherwise count only while active.
      if ((state_d == state_q) && active && !tick) begin
         cnt_d = cnt_q + CntW'(1);
      end

      // New rate is picked up on entry and at each period boundary, never mid-period.
      if (tick || ((state_d != state_q) && ((state_d == StRun) || (state_d == StStep)))) begin
         sel_act_d = bus.rate_sel;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= StIdle;
         cnt_q         <= '0;
         sel_act_q     <= '0;
         step_q        <= 1'b0;
         phase_q       <= 1'b0;
         cycle_count_q <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         sel_act_q     <= sel_act_d;
         step_q        <= step_d;
         phase_q       <= phase_d;
         cycle_count_q <= cycle_count_d;
      end
   end

   // Moore outputs: decoded from registered state only
   assign bus.cpu_ce      = tick;
   assign bus.phase       = phase_q;
   assign bus.state       = state_q;
   assign bus.halted      = (state_q == StHalted);
   assign bus.cycle_count = cycle_count_q;

endmodule

// File: tb/tb_cpu_clock_controller.sv
// Directed scenarios followed by a randomized run, all checked cycle by cycle against a
// countdown-based reference model of the scheduler.
module tb_cpu_clock_controller;

   localparam int unsigned SEL_W = 3;
   localparam int unsigned CNT_W = 4;

   logic clk;
   logic reset;

   cpu_clock_controller_if #(.SEL_W(SEL_W), .CNT_W(CNT_W)) bus ();

   cpu_clock_controller #(.SEL_W(SEL_W), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: mode 0=IDLE 1=RUN 2=STEP 3=HALTED; m_left = cycles still to wait
   // before the enable cycle of the current period.
   int m_state, m_left, m_phase, m_count, m_stepq;

   function automatic bit m_ce();
      return ((m_state == 1) || (m_state == 2)) && (m_left == 0);
   endfunction

   task automatic model_reset();
      m_state = 0; m_left = 0; m_phase = 0; m_count = 0; m_stepq = 0;
   endtask

   task automatic model_edge();
      bit ce;
      bit sedge;
      int nxt;
      ce    = m_ce();
      sedge = bus.step_req && (m_stepq == 0);
      nxt   = m_state;
      case (m_state)
         0: if (bus.halt_in) nxt = 3; else if (bus.run_req) nxt = 1; else if (sedge) nxt = 2;
         1: if (bus.halt_in) nxt = 3; else if (!bus.run_req) nxt = 0;
         2: if (bus.halt_in) nxt = 3; else if (ce) nxt = 0;
         default: if (!bus.halt_in && !bus.run_req) nxt = 0;
      endcase
      if (ce) begin
         m_phase = 1 - m_phase;
         m_count = (m_count + 1) % (1 << CNT_W);
      end
      if ((nxt == 1) || (nxt == 2)) begin
         if ((nxt != m_state) || ce) m_left = (1 << bus.rate_sel) - 1;
         else m_left = m_left - 1;
      end else begin
         m_left = 0;
      end
      m_state = nxt;
      m_stepq = bus.step_req ? 1 : 0;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic compare_all(input string tag);
      chk({tag, ".cpu_ce"}, 32'(bus.cpu_ce), 32'(m_ce()));
      chk({tag, ".state"}, 32'(bus.state), 32'(m_state));
      chk({tag, ".halted"}, 32'(bus.halted), 32'(m_state == 3));
      chk({tag, ".phase"}, 32'(bus.phase), 32'(m_phase));
      chk({tag, ".count"}, 32'(bus.cycle_count), 32'(m_count));
   endtask

   task automatic cyc(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      compare_all(tag);
   endtask

   // Asynchronous reset pulse launched away from the clock edge.
   task automatic async_reset();
      reset = 1'b0;
      model_reset();
      #1;
      compare_all("rst_now");
      @(posedge clk);
      #1;
      compare_all("rst_hold");
      reset = 1'b1;
   endtask

   int idx, pulses, guard;

   initial begin
      reset        = 1'b0;
      bus.rate_sel = 3'd2;
      bus.run_req  = 1'b0;
      bus.step_req = 1'b0;
      bus.halt_in  = 1'b0;
      model_reset();
      #12;
      compare_all("reset");
      @(posedge clk);
      #1;
      reset = 1'b1;
      cyc("idle");

      // RUN at s=2: first enable in the 4th cycle, then every 4
      bus.run_req = 1'b1;
      cyc("run_entry");
      idx = 1;
      while (!bus.cpu_ce && idx < 40) begin cyc("run_wait"); idx++; end
      chk("first_ce_s2", 32'(idx), 32'd4);
      pulses = 1; guard = 0;
      while (pulses < 5 && guard < 100) begin
         cyc("run_s2");
         if (bus.cpu_ce) pulses++;
         guard++;
      end
      cyc("run_s2_after5");
      chk("count_after5", 32'(bus.cycle_count), 32'd5);
      chk("phase_after5", 32'(bus.phase), 32'd1);

      // s=0 then switch to s=3 mid-run
      bus.run_req = 1'b0;
      cyc("to_idle");
      chk("idle_state", 32'(bus.state), 32'd0);
      bus.rate_sel = 3'd0;
      bus.run_req  = 1'b1;
      cyc("s0_entry");
      chk("s0_ce_first", 32'(bus.cpu_ce), 32'd1);
      cyc("s0_run");
      chk("s0_ce_second", 32'(bus.cpu_ce), 32'd1);
      bus.rate_sel = 3'd3;
      for (int k = 0; k < 2; k++) begin
         idx = 0;
         do begin cyc("s3_run"); idx++; end while (!bus.cpu_ce && idx < 40);
         chk("s3_period", 32'(idx), 32'd8);
      end

      // Single step at s=1, second edge during STEP ignored
      bus.run_req = 1'b0;
      cyc("to_idle2");
      bus.rate_sel = 3'd1;
      cyc("idle2");
      bus.step_req = 1'b1;
      cyc("step_entry");
      chk("step_state", 32'(bus.state), 32'd2);
      bus.step_req = 1'b0;
      cyc("step_pulse");
      chk("step_ce", 32'(bus.cpu_ce), 32'd1);
      bus.step_req = 1'b1;
      cyc("step_done");
      chk("step_back_idle", 32'(bus.state), 32'd0);
      pulses = 0;
      for (int k = 0; k < 6; k++) begin
         cyc("step_quiet");
         if (bus.cpu_ce) pulses++;
      end
      chk("step_no_extra", 32'(pulses), 32'd0);
      bus.step_req = 1'b0;

      // Halt coincident with an enable
      bus.run_req = 1'b1;
      cyc("halt_run_entry");
      guard = 0;
      while (!bus.cpu_ce && guard < 40) begin cyc("halt_wait"); guard++; end
      chk("halt_ce_seen", 32'(bus.cpu_ce), 32'd1);
      idx = (m_count + 1) % (1 << CNT_W);
      bus.halt_in = 1'b1;
      cyc("halt_edge");
      chk("halt_state", 32'(bus.state), 32'd3);
      chk("halt_flag", 32'(bus.halted), 32'd1);
      chk("halt_counted", 32'(bus.cycle_count), 32'(idx));
      pulses = 0;
      for (int k = 0; k < 5; k++) begin
         cyc("halted");
         if (bus.cpu_ce) pulses++;
      end
      chk("halted_no_ce", 32'(pulses), 32'd0);
      bus.halt_in = 1'b0;
      cyc("halt_run_held");
      chk("halt_stays", 32'(bus.state), 32'd3);
      bus.run_req = 1'b0;
      cyc("halt_release");
      chk("halt_to_idle", 32'(bus.state), 32'd0);

      // cycle_count wrap
      async_reset();
      bus.rate_sel = 3'd0;
      bus.run_req  = 1'b1;
      cyc("wrap_entry");
      repeat (15) cyc("wrap_run");
      chk("count_15", 32'(bus.cycle_count), 32'd15);
      cyc("wrap_16");
      chk("count_wrap", 32'(bus.cycle_count), 32'd0);

      // Reset mid-period
      bus.run_req = 1'b0;
      cyc("pre_rst_idle");
      bus.rate_sel = 3'd2;
      bus.run_req  = 1'b1;
      cyc("pre_rst_entry");
      cyc("pre_rst_c1");
      cyc("pre_rst_c2");
      bus.run_req = 1'b0;
      async_reset();
      chk("rst_ce", 32'(bus.cpu_ce), 32'd0);
      chk("rst_count", 32'(bus.cycle_count), 32'd0);
      repeat (3) cyc("post_rst_idle");
      bus.run_req = 1'b1;
      cyc("post_rst_entry");
      idx = 1;
      while (!bus.cpu_ce && idx < 40) begin cyc("post_rst_wait"); idx++; end
      chk("post_rst_first_ce", 32'(idx), 32'd4);

      // Randomized operation
      for (int k = 0; k < 1500; k++) begin
         if ($urandom_range(0, 19) == 0) bus.run_req = ~bus.run_req;
         if ($urandom_range(0, 3) == 0) bus.step_req = ~bus.step_req;
         if ($urandom_range(0, 49) == 0) bus.halt_in = 1'b1;
         else if ($urandom_range(0, 3) == 0) bus.halt_in = 1'b0;
         if ($urandom_range(0, 9) == 0) bus.rate_sel = 3'($urandom_range(0, 3));
         if ($urandom_range(0, 299) == 0) async_reset();
         else cyc("rand");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
